instr_decode: RTL and testbench

Decode stage of the 16-bit RISC pipeline, directly downstream of `Instr_Fetch`. Consumes `instr_fetch_out`/`hit_fetch_out` and decodes the instruction into fields and control signals. Reads operands from an internal 8x16 register file written by writeback, and presents everything in a registered ID/EX bundle. Handles pipeline stall, branch flush and fetch-miss bubbles.

---
 rtl/risc_pkg.sv | 38 +++
 rtl/reg_file.sv | 36 +++
 rtl/instr_decode.sv | 159 +++++++++++++++
 tb/tb_instr_decode.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared opcode/ALU encodings and decode control bundle for the 16-bit RISC pipeline.
// Pure definitions: no latency, no backpressure.
package risc_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_BNE   = 4'b0101;
  localparam logic [3:0] OP_JMP   = 4'b0110;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  // R-type alu_op is {1'b0, funct}, so these double as the funct codes.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic branch_eq;
    logic branch_ne;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 8x16 register file, 1 write / 2 read, r0 reads zero; reads are combinational with write-through bypass.
// Writes land on the clock edge; never stalls, no backpressure.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != '0) rdata_a = (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
    if (raddr_b != '0) rdata_b = (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];
  end

endmodule

// File: rtl/instr_decode.sv
// Decode stage: splits the fetched instruction into fields/controls, reads operands, registers the ID/EX bundle.
// One-cycle latency; stall freezes the bundle, flush/fetch-miss/illegal opcode insert a bubble.
module instr_decode #(
  parameter int DATA_W = risc_pkg::DATA_W,
  parameter int NREGS  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           instr_fetch_out,
  input  logic                        hit_fetch_out,
  input  logic                        PC_src,
  input  logic                        stall,
  input  logic                        wb_we,
  input  logic [risc_pkg::REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  output logic                        id_valid,
  output logic [DATA_W-1:0]           id_rs_val,
  output logic [DATA_W-1:0]           id_rt_val,
  output logic [risc_pkg::REG_AW-1:0] id_rd,
  output logic [risc_pkg::REG_AW-1:0] id_rs,
  output logic [risc_pkg::REG_AW-1:0] id_rt,
  output logic [DATA_W-1:0]           id_imm,
  output logic [3:0]                  id_alu_op,
  output logic                        id_reg_write,
  output logic                        id_mem_read,
  output logic                        id_mem_write,
  output logic                        id_mem_to_reg,
  output logic                        id_alu_src,
  output logic                        id_branch_eq,
  output logic                        id_branch_ne,
  output logic                        id_jump,
  output logic                        id_illegal
);
  import risc_pkg::*;

  typedef struct packed {
    logic                valid;
    logic                illegal;
    logic [DATA_W-1:0]   rs_val;
    logic [DATA_W-1:0]   rt_val;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs;
    logic [REG_AW-1:0]   rt;
    logic [DATA_W-1:0]   imm;
    logic [3:0]          alu_op;
    ctrl_t               ctrl;
  } idex_t;

  logic [3:0]        op;
  logic [REG_AW-1:0] rs_idx;
  logic [REG_AW-1:0] rt_idx;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              dec_illegal;
  idex_t             d;
  idex_t             q;

  assign op     = instr_fetch_out[15:12];
  assign rs_idx = instr_fetch_out[8:6];

  reg_file #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(REG_AW)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_idx),
    .raddr_b (rt_idx),
    .rdata_a (rs_val),
    .rdata_b (rt_val)
  );

  // I-type second source sits in [11:9] (store data / branch compare), R-type in [5:3].
  always_comb begin
    rt_idx      = instr_fetch_out[11:9];
    dec_illegal = 1'b0;
    d           = '0;
    d.valid     = 1'b1;
    d.rd        = instr_fetch_out[11:9];
    d.rs        = rs_idx;
    d.imm       = {{(DATA_W-6){instr_fetch_out[5]}}, instr_fetch_out[5:0]};
    d.alu_op    = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        rt_idx           = instr_fetch_out[5:3];
        d.imm            = '0;
        d.alu_op         = {1'b0, instr_fetch_out[2:0]};
        d.ctrl.reg_write = 1'b1;
      end
      OP_ADDI: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
      end
      OP_LW: begin
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.mem_read   = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
        d.ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        d.ctrl.mem_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        d.alu_op         = ALU_SUB;
        d.ctrl.branch_eq = 1'b1;
      end
      OP_BNE: begin
        d.alu_op         = ALU_SUB;
        d.ctrl.branch_ne = 1'b1;
      end
      OP_JMP: begin
        d.imm       = {{(DATA_W-12){instr_fetch_out[11]}}, instr_fetch_out[11:0]};
        d.ctrl.jump = 1'b1;
      end
      OP_NOP:  ;
      default: dec_illegal = 1'b1;
    endcase
    d.rt     = rt_idx;
    d.rs_val = rs_val;
    d.rt_val = rt_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (PC_src) begin
      q <= '0;
    end else if (stall) begin
      q <= q;
    end else if (!hit_fetch_out) begin
      q <= '0;
    end else if (dec_illegal) begin
      q         <= '0;
      q.illegal <= 1'b1;
    end else begin
      q <= d;
    end
  end

  assign id_valid      = q.valid;
  assign id_illegal    = q.illegal;
  assign id_rs_val     = q.rs_val;
  assign id_rt_val     = q.rt_val;
  assign id_rd         = q.rd;
  assign id_rs         = q.rs;
  assign id_rt         = q.rt;
  assign id_imm        = q.imm;
  assign id_alu_op     = q.alu_op;
  assign id_reg_write  = q.ctrl.reg_write;
  assign id_mem_read   = q.ctrl.mem_read;
  assign id_mem_write  = q.ctrl.mem_write;
  assign id_mem_to_reg = q.ctrl.mem_to_reg;
  assign id_alu_src    = q.ctrl.alu_src;
  assign id_branch_eq  = q.ctrl.branch_eq;
  assign id_branch_ne  = q.ctrl.branch_ne;
  assign id_jump       = q.ctrl.jump;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: hand-computed vectors, one task per scenario.
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_fetch_out;
  logic        hit_fetch_out;
  logic        PC_src;
  logic        stall;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        id_valid;
  logic [15:0] id_rs_val, id_rt_val, id_imm;
  logic [2:0]  id_rd, id_rs, id_rt;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
  logic        id_branch_eq, id_branch_ne, id_jump, id_illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_decode dut (
    .clk(clk), .rst(rst), .instr_fetch_out(instr_fetch_out), .hit_fetch_out(hit_fetch_out),
    .PC_src(PC_src), .stall(stall), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_rd(id_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_branch_eq(id_branch_eq),
    .id_branch_ne(id_branch_ne), .id_jump(id_jump), .id_illegal(id_illegal)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ins, input logic h, input logic pc, input logic st,
                       input logic we, input logic [2:0] a, input logic [15:0] dat);
    instr_fetch_out = ins;
    hit_fetch_out   = h;
    PC_src          = pc;
    stall           = st;
    wb_we           = we;
    wb_addr         = a;
    wb_data         = dat;
  endtask

  function automatic logic [7:0] ctrls();
    return {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
            id_alu_src, id_branch_eq, id_branch_ne, id_jump};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    drive(16'h0AE0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    tick; tick;
    rst = 1'b0;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", id_valid); end
    n_cmp++; if (ctrls() !== 8'h00) begin n_err++; $display("FAIL reset_ctrls got %h want 00", ctrls()); end
    n_cmp++; if ({id_rs_val, id_rt_val, id_imm} !== 48'h0) begin n_err++; $display("FAIL reset_data got %h want 0", {id_rs_val, id_rt_val, id_imm}); end
    n_cmp++; if ({id_rd, id_rs, id_rt, id_alu_op, id_illegal} !== 14'h0) begin n_err++; $display("FAIL reset_fields got %h want 0", {id_rd, id_rs, id_rt, id_alu_op, id_illegal}); end
  endtask

  task automatic test_add;
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234); tick;
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0010); tick;
    drive(16'h0AE0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", id_valid); end
    n_cmp++; if (id_rs_val !== 16'h1234) begin n_err++; $display("FAIL add_rs_val got %h want 1234", id_rs_val); end
    n_cmp++; if (id_rt_val !== 16'h0010) begin n_err++; $display("FAIL add_rt_val got %h want 0010", id_rt_val); end
    n_cmp++; if ({id_rd, id_rs, id_rt} !== {3'd5, 3'd3, 3'd4}) begin n_err++; $display("FAIL add_idx got %0d/%0d/%0d want 5/3/4", id_rd, id_rs, id_rt); end
    n_cmp++; if (id_alu_op !== 4'b0000) begin n_err++; $display("FAIL add_alu_op got %b want 0000", id_alu_op); end
    n_cmp++; if (ctrls() !== 8'h80) begin n_err++; $display("FAIL add_ctrls got %h want 80", ctrls()); end
  endtask

  task automatic test_lw;
    drive(16'h247F, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if (id_imm !== 16'hFFFF) begin n_err++; $display("FAIL lw_imm got %h want FFFF", id_imm); end
    n_cmp++; if (ctrls() !== 8'hD8) begin n_err++; $display("FAIL lw_ctrls got %h want D8", ctrls()); end
    n_cmp++; if ({id_rd, id_rs} !== {3'd2, 3'd1}) begin n_err++; $display("FAIL lw_idx got %0d/%0d want 2/1", id_rd, id_rs); end
    n_cmp++; if ({id_valid, id_illegal} !== 2'b10) begin n_err++; $display("FAIL lw_valid got %b want 10", {id_valid, id_illegal}); end
  endtask

  task automatic test_bypass;
    drive(16'h1443, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 16'hBEEF); tick;
    n_cmp++; if (id_rs_val !== 16'hBEEF) begin n_err++; $display("FAIL bypass_rs_val got %h want BEEF", id_rs_val); end
    n_cmp++; if (id_imm !== 16'h0003) begin n_err++; $display("FAIL addi_imm got %h want 0003", id_imm); end
    n_cmp++; if (ctrls() !== 8'h88) begin n_err++; $display("FAIL addi_ctrls got %h want 88", ctrls()); end
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'hFFFF); tick;
    // ADD r6,r1,r0 while r0 is being written again: neither storage nor bypass may leak into r0
    drive(16'h0C40, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'hAAAA); tick;
    n_cmp++; if (id_rt_val !== 16'h0000) begin n_err++; $display("FAIL r0_read got %h want 0000", id_rt_val); end
    n_cmp++; if (id_rs_val !== 16'hBEEF) begin n_err++; $display("FAIL r1_stored got %h want BEEF", id_rs_val); end
  endtask

  task automatic test_stall;
    logic [15:0] ins [3];
    ins[0] = 16'h247F; ins[1] = 16'h1443; ins[2] = 16'hA000;
    drive(16'h0EE1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if ({id_valid, id_alu_op, id_rd} !== {1'b1, 4'b0001, 3'd7}) begin n_err++; $display("FAIL sub_load got %b/%b/%0d want 1/0001/7", id_valid, id_alu_op, id_rd); end
    for (int i = 0; i < 3; i++) begin
      drive(ins[i], i[0], 1'b0, 1'b1, 1'b1, 3'd3, 16'h5555); tick;
      n_cmp++; if ({id_valid, id_alu_op, id_rd, id_rs_val, id_rt_val} !== {1'b1, 4'b0001, 3'd7, 16'h1234, 16'h0010})
        begin n_err++; $display("FAIL stall_hold_%0d got %b/%b/%0d/%h/%h want 1/0001/7/1234/0010", i, id_valid, id_alu_op, id_rd, id_rs_val, id_rt_val); end
    end
    drive(16'h0EE1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if (id_rs_val !== 16'h5555) begin n_err++; $display("FAIL stall_wb_write got %h want 5555", id_rs_val); end
  endtask

  task automatic test_stall_flush;
    drive(16'h0AE0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if ({id_valid, ctrls(), id_rd, id_alu_op} !== 16'h0) begin n_err++; $display("FAIL flush_over_stall got %b/%h/%0d/%b want 0/00/0/0000", id_valid, ctrls(), id_rd, id_alu_op); end
    drive(16'h0AE0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    drive(16'h247F, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if ({id_valid, ctrls(), id_imm} !== 25'h0) begin n_err++; $display("FAIL flush got %b/%h/%h want 0/00/0000", id_valid, ctrls(), id_imm); end
  endtask

  task automatic test_hit_miss;
    drive(16'h0AE0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      tick;
      n_cmp++; if ({id_valid, id_reg_write, id_rs_val} !== 18'h0) begin n_err++; $display("FAIL miss_bubble_%0d got %b/%b/%h want 0/0/0000", i, id_valid, id_reg_write, id_rs_val); end
    end
    hit_fetch_out = 1'b1; tick;
    n_cmp++; if ({id_valid, id_rs_val} !== {1'b1, 16'h5555}) begin n_err++; $display("FAIL miss_recover got %b/%h want 1/5555", id_valid, id_rs_val); end
  endtask

  task automatic test_illegal;
    drive(16'hA000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if ({id_illegal, id_valid, ctrls()} !== 10'b10_0000_0000) begin n_err++; $display("FAIL illegal got %b/%b/%h want 1/0/00", id_illegal, id_valid, ctrls()); end
    drive(16'hF000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if ({id_illegal, id_valid, ctrls()} !== 10'b01_0000_0000) begin n_err++; $display("FAIL nop got %b/%b/%h want 0/1/00", id_illegal, id_valid, ctrls()); end
  endtask

  task automatic test_branch_jump;
    drive(16'h4440, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if ({ctrls(), id_alu_op, id_rs, id_rt} !== {8'h04, 4'b0001, 3'd1, 3'd2}) begin n_err++; $display("FAIL beq got %h/%b/%0d/%0d want 04/0001/1/2", ctrls(), id_alu_op, id_rs, id_rt); end
    drive(16'h5440, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if ({ctrls(), id_alu_op} !== {8'h02, 4'b0001}) begin n_err++; $display("FAIL bne got %h/%b want 02/0001", ctrls(), id_alu_op); end
    drive(16'h6800, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if ({ctrls(), id_imm} !== {8'h01, 16'hF800}) begin n_err++; $display("FAIL jmp got %h/%h want 01/F800", ctrls(), id_imm); end
    drive(16'h3C85, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if ({ctrls(), id_imm, id_rt} !== {8'h28, 16'h0005, 3'd6}) begin n_err++; $display("FAIL sw got %h/%h/%0d want 28/0005/6", ctrls(), id_imm, id_rt); end
  endtask

  task automatic test_mid_reset;
    drive(16'h0AE0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    stall = 1'b1; tick;
    rst = 1'b1; tick;
    n_cmp++; if ({id_valid, ctrls(), id_rs_val, id_rt_val, id_rd} !== 44'h0) begin n_err++; $display("FAIL midrst_bundle got %b/%h/%h/%h/%0d want all 0", id_valid, ctrls(), id_rs_val, id_rt_val, id_rd); end
    rst = 1'b0;
    drive(16'h0AE0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if ({id_valid, id_rs_val, id_rt_val} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL midrst_regs got %b/%h/%h want 1/0000/0000", id_valid, id_rs_val, id_rt_val); end
    drive(16'h0C40, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000); tick;
    n_cmp++; if (id_rs_val !== 16'h0000) begin n_err++; $display("FAIL midrst_r1 got %h want 0000", id_rs_val); end
  endtask

  initial begin
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    rst = 1'b1;
    test_reset;
    test_add;
    test_lw;
    test_bypass;
    test_stall;
    test_stall_flush;
    test_hit_miss;
    test_illegal;
    test_branch_jump;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
